qupls_reglist_seq: RTL and testbench

QUPLS_REGLIST_SEQ -- requirements
Module: qupls_reglist_seq

---
 rtl/qupls_reglist_seq.sv | 138 +++++++++++++
 tb/tb_qupls_reglist_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/qupls_reglist_seq.sv
`default_nettype none
// ============================================================================
// Module   : qupls_reglist_seq
// Purpose  : Register-list sequencer. Expands a load/store-multiple bitmask
//            into one micro-op per selected register, lowest register first,
//            with a scaled memory offset per micro-op.
// Revision : 1.0  initial release
// ============================================================================
module qupls_reglist_seq #(
  parameter int NREG = 32,
  parameter int OFSW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic            start,
  input  logic            is_load,
  input  logic [NREG-1:0] mask,
  input  logic [2:0]      scale,
  input  logic            pack,
  output logic            reglist_active,
  output logic            stall,
  output logic            irq_defer,
  output logic [7:0]      aregno,
  output logic [7:0]      regcnt,
  output logic [OFSW-1:0] offset,
  output logic            ld,
  output logic            last,
  output logic            done
);

  localparam logic [1:0]      IDLE = 2'd0;
  localparam logic [1:0]      RUN  = 2'd1;
  localparam logic [NREG-1:0] ONE  = NREG'(1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [NREG-1:0] pending;
  logic [7:0]      cnt;
  logic [2:0]      scale_q;
  logic            pack_q;
  logic [7:0]      lsb_idx;
  logic [7:0]      off_base;
  logic            mask_nz;
  logic            one_left;
  logic            accept_start;
  logic            advance;

  assign mask_nz      = |mask;
  // Exactly one bit remains when clearing the lowest set bit empties the set.
  assign one_left     = (|pending) && ((pending & (pending - ONE)) == '0);
  // A start is only honoured from IDLE; the re-presented instruction seen
  // while RUN is ignored so the list is not restarted.
  assign accept_start = (state == IDLE) && start && en;
  assign advance      = (state == RUN) && en;

  // Locate the lowest set bit of the pending set (scan high to low so the
  // lowest index wins).
  always_comb begin
    lsb_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (pending[i]) lsb_idx = 8'(i);
    end
  end

  // State register; reset and flush both return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decision; flush overrides any start in the same cycle.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept_start && mask_nz) state_nxt = RUN;
        RUN:     if (en && one_left)          state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: latch the list on start, retire one register per advance,
  // and pulse done after an empty list or the final micro-op.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      cnt     <= '0;
      ld      <= 1'b0;
      done    <= 1'b0;
      scale_q <= '0;
      pack_q  <= 1'b0;
    end else if (flush) begin
      pending <= '0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      done <= (accept_start && !mask_nz) || (advance && one_left);
      if (accept_start) begin
        pending <= mask;
        ld      <= is_load;
        scale_q <= scale;
        pack_q  <= pack;
        cnt     <= '0;
      end else if (advance) begin
        pending <= pending & (pending - ONE);
        if (cnt != 8'hFF) cnt <= cnt + 8'd1;
      end
    end
  end

  // Output decode; everything except irq_defer, ld and done reads zero in IDLE.
  always_comb begin
    reglist_active = 1'b0;
    stall          = 1'b0;
    last           = 1'b0;
    aregno         = '0;
    regcnt         = '0;
    offset         = '0;
    off_base       = pack_q ? cnt : lsb_idx;
    irq_defer      = (state == IDLE) && start && mask_nz;
    if (state == RUN) begin
      reglist_active = 1'b1;
      last           = one_left;
      stall          = !one_left;
      aregno         = lsb_idx;
      regcnt         = cnt;
      offset         = OFSW'(off_base) << scale_q;
      irq_defer      = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qupls_reglist_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_qupls_reglist_seq
// Purpose  : Self-checking bench for qupls_reglist_seq; queue-based reference
//            model plus directed scenarios with literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_qupls_reglist_seq;

  localparam int NREG = 32;
  localparam int OFSW = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic            flush = 1'b0;
  logic            start = 1'b0;
  logic            is_load = 1'b0;
  logic [NREG-1:0] mask = '0;
  logic [2:0]      scale = '0;
  logic            pack = 1'b0;
  logic            reglist_active, stall, irq_defer, ld, last, done;
  logic [7:0]      aregno, regcnt;
  logic [OFSW-1:0] offset;

  int total = 0;
  int passed = 0;
  bit chk_on = 1'b0;

  qupls_reglist_seq #(.NREG(NREG), .OFSW(OFSW)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .start(start),
    .is_load(is_load), .mask(mask), .scale(scale), .pack(pack),
    .reglist_active(reglist_active), .stall(stall), .irq_defer(irq_defer),
    .aregno(aregno), .regcnt(regcnt), .offset(offset), .ld(ld),
    .last(last), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: remaining registers kept as an ascending queue.
  int q[$];
  bit m_run = 0;
  int m_cnt = 0;
  bit m_ld = 0;
  bit m_done = 0;
  int m_scale = 0;
  bit m_pack = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; q.delete(); m_cnt = 0; m_ld = 0; m_done = 0;
    end else if (flush) begin
      m_run = 0; q.delete(); m_cnt = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (en) begin
        if (!m_run && start) begin
          m_ld = is_load; m_scale = int'(scale); m_pack = pack; m_cnt = 0;
          q.delete();
          for (int r = 0; r < NREG; r++) if (mask[r]) q.push_back(r);
          if (q.size() == 0) m_done = 1;
          else               m_run = 1;
        end else if (m_run) begin
          void'(q.pop_front());
          m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
          if (q.size() == 0) begin m_run = 0; m_done = 1; end
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_on) begin
      int e_reg, e_cnt, e_off;
      e_reg = m_run ? q[0] : 0;
      e_cnt = m_run ? m_cnt : 0;
      e_off = m_run ? (((m_pack ? m_cnt : q[0]) << m_scale) & ((1 << OFSW) - 1)) : 0;
      cmp("m_active", 32'(reglist_active), 32'(m_run));
      cmp("m_aregno", 32'(aregno), e_reg);
      cmp("m_regcnt", 32'(regcnt), e_cnt);
      cmp("m_offset", 32'(offset), e_off);
      cmp("m_last",   32'(last),   32'(m_run && q.size() == 1));
      cmp("m_stall",  32'(stall),  32'(m_run && q.size() > 1));
      cmp("m_irq",    32'(irq_defer), 32'(m_run || (start && mask != '0)));
      cmp("m_ld",     32'(ld),     32'(m_ld));
      cmp("m_done",   32'(done),   32'(m_done));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [31:0] m, input logic [2:0] s, input logic p, input logic l);
    start = 1'b1; mask = m; scale = s; pack = p; is_load = l;
    step();
    start = 1'b0;
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    cmp("rst_active", 32'(reglist_active), 0);
    cmp("rst_done", 32'(done), 0);
    cmp("rst_ld", 32'(ld), 0);

    // Scenario 1: mask 0x89, scale 3, register-number offsets.
    launch(32'h89, 3'd3, 1'b0, 1'b1);
    @(negedge clk); cmp("s1_reg0", 32'(aregno), 0);  cmp("s1_off0", 32'(offset), 32'h000);
    cmp("s1_stall0", 32'(stall), 1);
    step(); @(negedge clk); cmp("s1_reg1", 32'(aregno), 3); cmp("s1_off1", 32'(offset), 32'h018);
    step(); @(negedge clk); cmp("s1_reg2", 32'(aregno), 7); cmp("s1_off2", 32'(offset), 32'h038);
    cmp("s1_last", 32'(last), 1); cmp("s1_stall2", 32'(stall), 0);
    step(); @(negedge clk); cmp("s1_done", 32'(done), 1); cmp("s1_idle", 32'(reglist_active), 0);
    step(); @(negedge clk); cmp("s1_done_once", 32'(done), 0);

    // Scenario 2: same mask, ordinal offsets.
    launch(32'h89, 3'd3, 1'b1, 1'b0);
    @(negedge clk); cmp("s2_off0", 32'(offset), 32'h000); cmp("s2_cnt0", 32'(regcnt), 0);
    step(); @(negedge clk); cmp("s2_off1", 32'(offset), 32'h008); cmp("s2_cnt1", 32'(regcnt), 1);
    step(); @(negedge clk); cmp("s2_off2", 32'(offset), 32'h010); cmp("s2_cnt2", 32'(regcnt), 2);
    step(); step();

    // Scenario 3: empty mask.
    start = 1'b1; mask = '0;
    @(negedge clk); cmp("s3_irq", 32'(irq_defer), 0);
    step(); start = 1'b0;
    @(negedge clk); cmp("s3_active", 32'(reglist_active), 0); cmp("s3_done", 32'(done), 1);
    cmp("s3_stall", 32'(stall), 0);
    step(); @(negedge clk); cmp("s3_done_once", 32'(done), 0);

    // Scenario 4: sparse mask with en held low on the first micro-op.
    launch(32'h8000_0001, 3'd2, 1'b0, 1'b1);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); cmp("s4_hold_reg", 32'(aregno), 0); cmp("s4_hold_stall", 32'(stall), 1);
      step();
    end
    en = 1'b1;
    @(negedge clk); cmp("s4_reg0", 32'(aregno), 0);
    step(); @(negedge clk); cmp("s4_reg31", 32'(aregno), 31); cmp("s4_off31", 32'(offset), 32'h07C);
    cmp("s4_last", 32'(last), 1);
    step(); @(negedge clk); cmp("s4_done", 32'(done), 1);
    step();

    // Scenario 5: flush on the second micro-op, then a fresh list.
    launch(32'hF, 3'd0, 1'b0, 1'b0);
    step(); @(negedge clk); cmp("s5_reg1", 32'(aregno), 1);
    flush = 1'b1; step(); flush = 1'b0;
    @(negedge clk); cmp("s5_flush_idle", 32'(reglist_active), 0); cmp("s5_flush_nodone", 32'(done), 0);
    cmp("s5_flush_cnt", 32'(regcnt), 0);
    step(); @(negedge clk); cmp("s5_flush_nodone2", 32'(done), 0);
    launch(32'h2, 3'd1, 1'b0, 1'b1);
    @(negedge clk); cmp("s5_new_reg", 32'(aregno), 1); cmp("s5_new_off", 32'(offset), 32'h002);
    cmp("s5_new_last", 32'(last), 1);
    step(); @(negedge clk); cmp("s5_new_done", 32'(done), 1);
    step();

    // Flush beats start in the same cycle.
    start = 1'b1; flush = 1'b1; mask = 32'h5;
    step(); start = 1'b0; flush = 1'b0;
    @(negedge clk); cmp("fl_prio_idle", 32'(reglist_active), 0); cmp("fl_prio_done", 32'(done), 0);

    // Scenario 6: reset mid-list, then the full mask with start held early.
    launch(32'hF, 3'd0, 1'b0, 1'b1);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk); cmp("s6_rst_idle", 32'(reglist_active), 0); cmp("s6_rst_done", 32'(done), 0);
    cmp("s6_rst_ld", 32'(ld), 0);
    start = 1'b1; mask = 32'hFFFF_FFFF; scale = 3'd0; pack = 1'b1; is_load = 1'b1;
    step();
    for (int k = 0; k < 32; k++) begin
      if (k == 10) start = 1'b0;
      @(negedge clk);
      cmp("s6_cnt", 32'(regcnt), k); cmp("s6_reg", 32'(aregno), k);
      cmp("s6_irq", 32'(irq_defer), 1);
      step();
    end
    @(negedge clk); cmp("s6_done", 32'(done), 1); cmp("s6_idle", 32'(reglist_active), 0);
    step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
